// File: rtl/btn_cond_pkg.sv
// Shared state encoding and default timing constants for btn_conditioner.
// Optional long-press feature is enabled by defining BTN_CONDITIONER_LONG_EN.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DB_HIGH = 2'd1,
        HELD    = 2'd2,
        DB_LOW  = 2'd3
    } state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_LONG_CYCLES     = 1024;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the asynchronous push-button input.
// Used by btn_conditioner (long-press option: BTN_CONDITIONER_LONG_EN).
module btn_sync (
    input  logic clk,
    input  logic res,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button debouncer producing a held request with press count and overrun flag.
// Define BTN_CONDITIONER_LONG_EN to add the LONG_CYCLES hold counter and long_press pulse.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_CONDITIONER_LONG_EN
    ,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
`endif
) (
    input  logic       clk,
    input  logic       res,
    input  logic       btn_raw,
    output logic       req_valid,
    input  logic       req_ack,
    output logic       btn_level,
    output logic       overrun,
    output logic [7:0] press_cnt
`ifdef BTN_CONDITIONER_LONG_EN
    ,
    output logic       long_press
`endif
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             sync;
    logic             press;

    btn_sync u_sync (
        .clk (clk),
        .res (res),
        .d   (btn_raw),
        .q   (sync)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // press marks the DB_HIGH->HELD edge; it is the only source of new requests
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        press   = 1'b0;
        case (state)
            IDLE: begin
                if (sync) begin
                    state_n = DB_HIGH;
                    cnt_n   = '0;
                end
            end
            DB_HIGH: begin
                if (!sync) begin
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = HELD;
                    press   = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync) begin
                    state_n = DB_LOW;
                    cnt_n   = '0;
                end
            end
            DB_LOW: begin
                if (sync) begin
                    state_n = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign btn_level = (state == HELD) || (state == DB_LOW);

    // A new press outranks a same-edge ack, so the request stays asserted
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            req_valid <= 1'b0;
            overrun   <= 1'b0;
            press_cnt <= '0;
        end else if (press) begin
            req_valid <= 1'b1;
            press_cnt <= press_cnt + 8'd1;
            if (req_valid && !req_ack) begin
                overrun <= 1'b1;
            end
        end else if (req_ack) begin
            req_valid <= 1'b0;
        end
    end

`ifdef BTN_CONDITIONER_LONG_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Counter saturates at LONG_CYCLES, so the LONG_CYCLES-1 crossing happens once per press
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= (state == HELD) && (hold_cnt == HOLD_W'(LONG_CYCLES - 2));
            if (state == IDLE) begin
                hold_cnt <= '0;
            end else if ((state == HELD) && (hold_cnt != HOLD_W'(LONG_CYCLES))) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end
`endif

endmodule
